// File: rtl/osc_meter_pkg.sv
// Shared types and constants for the oscillator frequency meter.
package osc_meter_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } meter_state_e;

  // Oscillator tap indices (raw oscillator and divider outputs).
  localparam logic [1:0] TAP_RAW  = 2'd0;
  localparam logic [1:0] TAP_DIV2 = 2'd1;
  localparam logic [1:0] TAP_DIV4 = 2'd2;
  localparam logic [1:0] TAP_DIV8 = 2'd3;

  // Window counter must hold 2^(win_log2+3)-1, the longest selectable window.
  function automatic int unsigned win_cnt_w(input int unsigned win_log2);
    return win_log2 + 32'd4;
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Tap synchroniser: SYNC_STAGES flop chain followed by a rising-edge pulse
// generator on the last stage.
module osc_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tap,
  output logic o_edge_pulse_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Bring the asynchronous tap into clk and keep one delayed copy for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_tap};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge_pulse_c = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/osc_freq_meter.sv
// Oscillator frequency meter: selects a tap, synchronises it and counts its
// rising edges over a programmable window of system clocks.
// Optional feature macro: OSC_METER_CONTINUOUS_EN (back-to-back windows while
// start stays high, without repeating the settle phase).
module osc_freq_meter
  import osc_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WIN_LOG2    = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       osc_tap,
  input  logic             start,
  input  logic [1:0]       tap_sel,
  input  logic [1:0]       win_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             overflow
);

  localparam int unsigned WCNT_W = win_cnt_w(WIN_LOG2);
  localparam logic [WCNT_W-1:0] SETTLE_LAST = WCNT_W'(SYNC_STAGES);

  meter_state_e      r_state;
  logic [1:0]        r_tap_sel;
  logic [1:0]        r_win_sel;
  logic [WCNT_W-1:0] r_win_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_ovf;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_result;
  logic              r_overflow;

  logic              w_tap;
  logic              w_edge;
  logic [WCNT_W-1:0] w_win_last;
  logic              w_win_end;
  logic              w_cnt_max;
  logic [CNT_W-1:0]  w_edge_next;
  logic              w_ovf_next;

  // Tap mux driven by the captured selection.
  always_comb begin
    w_tap = osc_tap[0];
    case (r_tap_sel)
      TAP_RAW:  w_tap = osc_tap[0];
      TAP_DIV2: w_tap = osc_tap[1];
      TAP_DIV4: w_tap = osc_tap[2];
      TAP_DIV8: w_tap = osc_tap[3];
      default:  w_tap = osc_tap[0];
    endcase
  end

  osc_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_tap          (w_tap),
    .o_edge_pulse_c (w_edge)
  );

  // Window terminal count and saturating edge count for the current cycle.
  always_comb begin
    w_win_last  = (WCNT_W'(1) << (WIN_LOG2 + 32'(r_win_sel))) - WCNT_W'(1);
    w_win_end   = (r_win_cnt == w_win_last);
    w_cnt_max   = (r_edge_cnt == {CNT_W{1'b1}});
    w_edge_next = (w_edge && !w_cnt_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
    w_ovf_next  = r_ovf | (w_edge & w_cnt_max);
  end

  // Measurement sequencer with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tap_sel  <= TAP_RAW;
      r_win_sel  <= 2'd0;
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_tap_sel <= tap_sel;
            r_win_sel <= win_sel;
            r_win_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_win_cnt == SETTLE_LAST) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
            r_state    <= MEASURE;
          end else begin
            r_win_cnt <= r_win_cnt + WCNT_W'(1);
          end
        end
        MEASURE: begin
          if (w_win_end) begin
            r_result   <= w_edge_next;
            r_overflow <= w_ovf_next;
            r_done     <= 1'b1;
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
`ifdef OSC_METER_CONTINUOUS_EN
            if (start) begin
              r_state <= MEASURE;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
`else
            r_state <= IDLE;
            r_busy  <= 1'b0;
`endif
          end else begin
            r_win_cnt  <= r_win_cnt + WCNT_W'(1);
            r_edge_cnt <= w_edge_next;
            r_ovf      <= w_ovf_next;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter: a 16-bit and an 8-bit counter instance
// share stimulus; taps come from a clock-synchronous divider so edge counts
// over a window are exact.
module tb_osc_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  osc_tap;
  logic        start;
  logic [1:0]  tap_sel;
  logic [1:0]  win_sel;

  logic        busy, done, overflow;
  logic [15:0] result;
  logic        busy8, done8, overflow8;
  logic [7:0]  result8;

  logic [3:0]  ph = 4'd0;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int n_done;
  int busy_seen;

  always #5 clk = ~clk;

  // Tap model: [0] period 2, [1] period 4, [2] period 8, [3] period 16 clocks.
  always @(negedge clk) ph <= ph + 4'd1;
  assign osc_tap = ph;

  osc_freq_meter #(.CNT_W(16), .WIN_LOG2(10), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .osc_tap(osc_tap), .start(start),
    .tap_sel(tap_sel), .win_sel(win_sel),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  osc_freq_meter #(.CNT_W(8), .WIN_LOG2(10), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .osc_tap(osc_tap), .start(start),
    .tap_sel(tap_sel), .win_sel(win_sel),
    .busy(busy8), .done(done8), .result(result8), .overflow(overflow8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue a one-cycle start and return the start-to-done latency (-1 on timeout).
  task automatic measure(input logic [1:0] ts, input logic [1:0] ws, input int budget,
                         output int latency);
    @(negedge clk);
    start = 1'b1; tap_sel = ts; win_sel = ws;
    @(negedge clk);
    start = 1'b0;
    latency = -1;
    check("busy_rise", 32'(busy), 32'd1);
    for (int t = 1; t <= budget; t++) begin
      if (done) begin
        latency = t;
        break;
      end
      @(negedge clk);
    end
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tap_sel = 2'd0; win_sel = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Period-16 tap, base window.
    measure(2'd3, 2'd0, 1200, lat);
    check("t1_latency", 32'(lat), 32'd1028);
    check("t1_result", 32'(result), 32'd64);
    check("t1_overflow", 32'(overflow), 32'd0);
    check("t1_result8", 32'(result8), 32'd64);
    check("t1_done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    check("t1_done_low", 32'(done), 32'd0);
    check("t1_result_hold", 32'(result), 32'd64);

    // Period-16 tap, 4096-cycle window; 8-bit instance saturates.
    measure(2'd3, 2'd2, 4300, lat);
    check("t2_latency", 32'(lat), 32'd4100);
    check("t2_result", 32'(result), 32'd256);
    check("t2_overflow", 32'(overflow), 32'd0);
    check("t2_result8", 32'(result8), 32'd255);
    check("t2_overflow8", 32'(overflow8), 32'd1);

    // Second start while busy is ignored: exactly one done, at the usual latency.
    @(negedge clk);
    start = 1'b1; tap_sel = 2'd3; win_sel = 2'd0;
    @(negedge clk);
    start = 1'b0;
    n_done = 0; lat = -1;
    for (int t = 1; t <= 1300; t++) begin
      if (t == 100) begin start = 1'b1; tap_sel = 2'd0; win_sel = 2'd3; end
      if (t == 101) start = 1'b0;
      if (done) begin
        n_done++;
        if (lat < 0) lat = t;
      end
      @(negedge clk);
    end
    check("t4_done_count", 32'(n_done), 32'd1);
    check("t4_latency", 32'(lat), 32'd1028);
    check("t4_result", 32'(result), 32'd64);
    check("t4_busy_idle", 32'(busy), 32'd0);

    // Period-4 tap: 256 edges; 8-bit instance saturates without wrapping.
    measure(2'd1, 2'd0, 1200, lat);
    check("t3_latency", 32'(lat), 32'd1028);
    check("t3_result", 32'(result), 32'd256);
    check("t3_overflow", 32'(overflow), 32'd0);
    check("t3_result8", 32'(result8), 32'd255);
    check("t3_overflow8", 32'(overflow8), 32'd1);

    // Reset mid-measurement aborts with no done.
    @(negedge clk);
    start = 1'b1; tap_sel = 2'd2; win_sel = 2'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_result", 32'(result), 32'd0);
    check("t5_rst_overflow", 32'(overflow), 32'd0);
    check("t5_rst_result8", 32'(result8), 32'd0);
    check("t5_rst_overflow8", 32'(overflow8), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0; busy_seen = 0;
    for (int t = 0; t < 1200; t++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) busy_seen++;
    end
    check("t5_no_done", 32'(n_done), 32'd0);
    check("t5_no_busy", 32'(busy_seen), 32'd0);
    measure(2'd2, 2'd0, 1200, lat);
    check("t5_new_latency", 32'(lat), 32'd1028);
    check("t5_new_result", 32'(result), 32'd128);

    // Start held high: back-to-back windows; drop start at the third done.
    @(negedge clk);
    start = 1'b1; tap_sel = 2'd3; win_sel = 2'd0;
    n_done = 0;
    for (int t = 1; t <= 4400; t++) begin
      @(negedge clk);
      if (t == 1500) check("t6_busy_mid", 32'(busy), 32'd1);
      if (done) begin
`ifdef OSC_METER_CONTINUOUS_EN
        check("t6_done_time", 32'(t), 32'(1028 + 1024 * n_done));
`else
        check("t6_done_time", 32'(t), 32'(1028 * (n_done + 1)));
`endif
        check("t6_result", 32'(result), 32'd64);
        n_done++;
        if (n_done == 3) start = 1'b0;
      end
    end
`ifdef OSC_METER_CONTINUOUS_EN
    check("t6_done_count", 32'(n_done), 32'd4);
`else
    check("t6_done_count", 32'(n_done), 32'd3);
`endif
    check("t6_busy_end", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
